multicycle_ctrl: RTL

//  Multicycle fetch/decode/control sequencer; drives the regfile/ALU/data-mem datapath control inputs.

---
 rtl/ctrl_pkg.sv | 69 ++++++
 rtl/ctrl_decode.sv | 60 ++++++
 rtl/multicycle_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle control sequencer: opcodes, FSM states,
// the decoded control bundle and instruction field helpers.
package ctrl_pkg;

   typedef enum logic [3:0] {
      OP_ADDI = 4'h8,
      OP_LW   = 4'h9,
      OP_SW   = 4'hA,
      OP_BEQ  = 4'hB,
      OP_LI   = 4'hC,
      OP_NOP0 = 4'hD,
      OP_NOP1 = 4'hE,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALTED
   } state_e;

   localparam logic [3:0] ALUOP_ADD = 4'h0;
   localparam logic [3:0] ALUOP_BEQ = 4'h8;

   typedef struct packed {
      logic        mem_to_reg;
      logic        alu_src1;
      logic        alu_src2;
      logic [3:0]  alu_op;
      logic [2:0]  rd_addr1;
      logic [2:0]  rd_addr2;
      logic [2:0]  wr_addr;
      logic [15:0] imm;
      logic        has_mem;
      logic        has_wb;
      logic        is_sw;
      logic        is_beq;
      logic        is_halt;
   } ctrl_t;

   function automatic logic [3:0] f_op(input logic [15:0] ir);
      return ir[15:12];
   endfunction

   function automatic logic [2:0] f_rd(input logic [15:0] ir);
      return ir[11:9];
   endfunction

   function automatic logic [2:0] f_rs1(input logic [15:0] ir);
      return ir[8:6];
   endfunction

   function automatic logic [2:0] f_rs2(input logic [15:0] ir);
      return ir[5:3];
   endfunction

   function automatic logic [15:0] f_sext6(input logic [15:0] ir);
      return {{10{ir[5]}}, ir[5:0]};
   endfunction

   function automatic logic [15:0] f_sext9(input logic [15:0] ir);
      return {{7{ir[8]}}, ir[8:0]};
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: IR word to datapath control bundle and
// sequencing flags. IR=0 decodes to an all-zero datapath control set.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [15:0] i_ir,
   output ctrl_t       o_ctrl
);

   logic [3:0] w_op;

   assign w_op = f_op(i_ir);

   always_comb begin
      o_ctrl          = '0;
      o_ctrl.alu_op   = ALUOP_ADD;
      o_ctrl.rd_addr1 = f_rs1(i_ir);
      o_ctrl.rd_addr2 = f_rs2(i_ir);
      o_ctrl.wr_addr  = f_rd(i_ir);
      o_ctrl.imm      = f_sext6(i_ir);
      if (!w_op[3]) begin
         o_ctrl.alu_op = w_op;
         o_ctrl.has_wb = 1'b1;
      end else begin
         case (w_op)
            OP_ADDI: begin
               o_ctrl.alu_src2 = 1'b1;
               o_ctrl.has_wb   = 1'b1;
            end
            OP_LW: begin
               o_ctrl.alu_src2   = 1'b1;
               o_ctrl.mem_to_reg = 1'b1;
               o_ctrl.has_mem    = 1'b1;
               o_ctrl.has_wb     = 1'b1;
            end
            OP_SW: begin
               o_ctrl.alu_src2 = 1'b1;
               o_ctrl.rd_addr2 = f_rd(i_ir);
               o_ctrl.has_mem  = 1'b1;
               o_ctrl.is_sw    = 1'b1;
            end
            OP_BEQ: begin
               o_ctrl.alu_op   = ALUOP_BEQ;
               o_ctrl.rd_addr1 = f_rd(i_ir);
               o_ctrl.rd_addr2 = f_rs1(i_ir);
               o_ctrl.is_beq   = 1'b1;
            end
            OP_LI: begin
               o_ctrl.alu_src1 = 1'b1;
               o_ctrl.alu_src2 = 1'b1;
               o_ctrl.imm      = f_sext9(i_ir);
               o_ctrl.has_wb   = 1'b1;
            end
            OP_HALT: o_ctrl.is_halt = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the FSM, PC, IR and
// retired-instruction counter; datapath controls are decoded from the IR.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned PC_W  = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [15:0]      imem_rdata,
   input  logic             take_branch,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             MemToReg,
   output logic             ALUSrc1,
   output logic             ALUSrc2,
   output logic [3:0]       ALUOp,
   output logic [2:0]       rd_addr1,
   output logic [2:0]       rd_addr2,
   output logic [2:0]       wr_addr,
   output logic [15:0]      imm,
   output logic [PC_W-1:0]  pc,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   state_e           r_state;
   state_e           w_state_next;
   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  w_pc_next;
   logic [15:0]      r_ir;
   logic [CNT_W-1:0] r_cnt;
   logic             w_retire;
   ctrl_t            w_ctrl;

   ctrl_decode u_decode (
      .i_ir   (r_ir),
      .o_ctrl (w_ctrl)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (run) w_state_next = ST_FETCH;
         ST_FETCH:  w_state_next = ST_DECODE;
         ST_DECODE: w_state_next = ST_EXEC;
         ST_EXEC: begin
            if (w_ctrl.is_halt)      w_state_next = ST_HALTED;
            else if (w_ctrl.has_mem) w_state_next = ST_MEM;
            else if (w_ctrl.has_wb)  w_state_next = ST_WB;
            else                     w_state_next = ST_FETCH;
         end
         ST_MEM:    w_state_next = w_ctrl.has_wb ? ST_WB : ST_FETCH;
         ST_WB:     w_state_next = ST_FETCH;
         ST_HALTED: w_state_next = ST_HALTED;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Branch offset is relative to pc+1 and wraps with the PC width.
   assign w_pc_next = r_pc + PC_W'(1) +
                      ((w_ctrl.is_beq && take_branch) ? w_ctrl.imm[PC_W-1:0] : '0);

   assign w_retire = (r_state == ST_EXEC || r_state == ST_MEM || r_state == ST_WB) &&
                     (w_state_next == ST_FETCH || w_state_next == ST_HALTED);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_ir    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_DECODE) r_ir <= imem_rdata;
         // HALT keeps the PC on its own address so fetch stays frozen there.
         if (r_state == ST_EXEC && !w_ctrl.is_halt) r_pc <= w_pc_next;
         if (w_retire && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign halted      = (r_state == ST_HALTED);
   assign instr_count = r_cnt;
   assign RegWrite    = (r_state == ST_WB);
   assign MemWrite    = (r_state == ST_MEM) && w_ctrl.is_sw;
   assign MemToReg    = w_ctrl.mem_to_reg;
   assign ALUSrc1     = w_ctrl.alu_src1;
   assign ALUSrc2     = w_ctrl.alu_src2;
   assign ALUOp       = w_ctrl.alu_op;
   assign rd_addr1    = w_ctrl.rd_addr1;
   assign rd_addr2    = w_ctrl.rd_addr2;
   assign wr_addr     = w_ctrl.wr_addr;
   assign imm         = w_ctrl.imm;

endmodule
